// File: rtl/led_scan_sequencer.sv
// Column scan sequencer for the Game of Life LED matrix: blank/drive timing per column
// and a double-buffered cell image that swaps only at frame wrap.
module led_scan_sequencer #(
  parameter int N            = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic                 ena,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_start
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int XW   = $clog2(N) + 1;

  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_scan_sequencer: N=%0d out of range 1..8", N);
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("led_scan_sequencer: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("led_scan_sequencer: BLANK_CYCLES must be >= 1");
  end

  typedef enum logic {BLANK, DRIVE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [XW-1:0]    x_q;
  logic             ena_q;
  logic             fs_q;
  logic [N*N-1:0]   cells_q;
  logic [N*N-1:0]   pend_q;
  logic             pending_q;

  logic blank_done_d, drive_done_d, col_last_d, wrap_d, xfer_d;

  assign blank_done_d = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
  assign drive_done_d = (state_q == DRIVE) && (cnt_q == CW'(DWELL_CYCLES - 1));
  assign col_last_d   = (x_q == XW'(N - 1));
  assign wrap_d       = drive_done_d && col_last_d;
  assign xfer_d       = cells_valid && !pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      x_q       <= '0;
      ena_q     <= 1'b0;
      fs_q      <= 1'b0;
      cells_q   <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      fs_q <= wrap_d;
      case (state_q)
        BLANK: begin
          if (blank_done_d) begin
            state_q <= DRIVE;
            ena_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DRIVE: begin
          if (drive_done_d) begin
            // x only moves on entry to BLANK, so it is stable whenever ena is high
            state_q <= BLANK;
            ena_q   <= 1'b0;
            cnt_q   <= '0;
            x_q     <= col_last_d ? '0 : x_q + XW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= BLANK;
          ena_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
      // A transfer needs pending==0 and a swap needs pending==1, so they never collide;
      // data captured on a wrap edge therefore waits for the following wrap.
      if (xfer_d) begin
        pend_q    <= cells_in;
        pending_q <= 1'b1;
      end else if (wrap_d && pending_q) begin
        cells_q   <= pend_q;
        pending_q <= 1'b0;
      end
    end
  end

  assign cells_ready = ~pending_q;
  assign ena         = ena_q;
  assign x           = x_q;
  assign cells       = cells_q;
  assign frame_start = fs_q;

endmodule

// File: doc/led_scan_sequencer.md
# led_scan_sequencer

Sequential front end for the LED array column driver in the Game of Life display path. It time-multiplexes the N×N LED matrix by stepping the column index `x` through 0..N-1. Each column is held lit for a programmable dwell time, separated by a blanking gap that prevents ghosting. It also double-buffers the cell image so that a new generation from the Conway engine takes effect only at a frame boundary. Its `ena`, `x` and `cells` outputs feed the column driver directly.

## Interface
- `N`, 3: Conway grid size. Legal range is 1..8; `$error` if out of range.
- `DWELL_CYCLES`, 1000: clock cycles a column is driven (`ena`=1). Must be ≥1.
- `BLANK_CYCLES`, 16: clock cycles of blanking (`ena`=0) before each column. Must be ≥1.

- `clk` input, 1: sole clock. All state updates on its rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `cells_in` input, N*N: next generation from the Conway engine. Row r occupies bits [r*N +: N].
- `cells_valid` input, 1: `cells_in` holds a new generation.
- `cells_ready` output, 1: the pending buffer is free. A transfer occurs on `cells_valid && cells_ready` at a clock edge.
- `ena` output, 1: column drive enable to the driver.
- `x` output, $clog2(N)+1: current column index, always 0..N-1.
- `cells` output, N*N: active (displayed) cell image.
- `frame_start` output, 1: one-cycle pulse marking the start of a new frame.

## Operation
- Two-state FSM: BLANK and DRIVE, with a dwell/blank counter `cnt` of width $clog2(max(DWELL_CYCLES,BLANK_CYCLES))+1.
- BLANK:
  - `ena`=0.
  - If `cnt`==BLANK_CYCLES-1: go to DRIVE with `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- DRIVE:
  - `ena`=1.
  - If `cnt`==DWELL_CYCLES-1: go to BLANK with `cnt`←0, and `x`←(`x`==N-1) ? 0 : `x`+1.
  - Otherwise `cnt`←`cnt`+1.
- Frame wrap is the DRIVE→BLANK edge at which `x` goes from N-1 to 0. On that edge:
  - `frame_start`←1 for exactly one cycle.
  - If `pending`=1: `cells`←`pend_buf` and `pending`←0.
- `x` changes only on entry to BLANK, so `x` is never changed while `ena`=1.
- Input handshake:
  - `cells_ready` = ~`pending`, combinational from the register.
  - On `cells_valid && cells_ready`: `pend_buf`←`cells_in` and `pending`←1.
  - `cells_in` is sampled only at the transfer edge.
  - While `pending`=1 further offers stall and are not dropped; the producer must hold `cells_valid` and `cells_in`.
- Simultaneous transfer and frame wrap with `pending`=0: the new data goes into `pend_buf` and is displayed at the following wrap, not the current one.
- Simultaneous wrap with `pending`=1: `cells` updates. `cells_ready` rises the cycle after the wrap, never on the same edge.
- N=1: `x` stays 0 and every DRIVE→BLANK edge is a frame wrap.
- `ena`, `x`, `cells` and `frame_start` are driven directly from registers, with no combinational path from inputs.

## Timing
- Reset values (`rst_n`=0, applied asynchronously):
  - state=BLANK, `cnt`=0, `x`=0, `ena`=0.
  - `cells`=0, `pend_buf`=0, `pending`=0 (so `cells_ready`=1).
  - `frame_start`=0.
- After `rst_n` rises, `ena` stays low for BLANK_CYCLES cycles (counting the reset-exit cycle), then is high for DWELL_CYCLES cycles.
- Column period is BLANK_CYCLES+DWELL_CYCLES. Frame period is N*(BLANK_CYCLES+DWELL_CYCLES).
- No `frame_start` pulse is generated on reset exit; the first pulse is at the first wrap.
- Latency of a transfer accepted in frame k: it is displayed from the wrap ending frame k. If accepted on the wrap edge itself, it is displayed from the next wrap.
- Reset asserted mid-frame: all registers return to reset values immediately (async), and an accepted but undisplayed generation is discarded.

## Test plan
- N=3, DWELL=4, BLANK=2, release reset → `ena`=0 for 2 cycles then 1 for 4 cycles with `x`=0. The pattern repeats for `x`=1 and `x`=2. The 18-cycle frame wraps to `x`=0 with `frame_start`=1 for exactly 1 cycle. `x` never changes while `ena`=1.
- Offer `cells_in`=9'b101010101 mid-frame → `cells_ready` drops the next cycle. `cells` stays 0 until the wrap edge, then becomes 101010101 together with `frame_start`. `cells_ready` returns to 1 the cycle after the wrap.
- Offer A, then hold B valid while `pending`=1 → B is stalled and not captured. The wrap shows A, and B is captured the cycle after the wrap. B is shown at the next wrap, and no generation is lost.
- Assert `cells_valid` with C exactly on the wrap edge with `pending`=0 → `cells` is unchanged at this wrap and equals C after the next wrap (18 cycles later).
- Pulse `rst_n` low during DRIVE of `x`=2 with `pending`=1 → outputs go to reset values immediately and `cells_ready`=1. The first column after release is `x`=0, and the discarded pending data never appears.
- Sweep N=1 and N=8 with DWELL=1 and BLANK=1 → `x` stays in 0..N-1 and `ena` alternates 0/1 every cycle. For N=1, `frame_start` pulses once every 2 cycles.
